seg7_scan_scheduler: RTL and testbench



---
 rtl/seg7_scan_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_seg7_scan_scheduler.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_scheduler.sv
// Eight-digit (max) multiplexed seven-segment scan scheduler with a tear-free double-buffered frame.
// Define SEG7_LZB_EN to blank leading-zero digits when a frame is transferred.
module seg7_scan_scheduler #(
    parameter int NUM_DIGITS  = 8,
    parameter int DIGIT_TICKS = 50000,
    parameter int BLANK_TICKS = 500
) (
    input  logic                      clk_i,
    input  logic                      reset_n,
    input  logic                      load_valid_i,
    output logic                      load_ready_o,
    input  logic [4*NUM_DIGITS-1:0]   digits_i,
    input  logic [NUM_DIGITS-1:0]     dp_i,
    input  logic [NUM_DIGITS-1:0]     digit_en_i,
    output logic [6:0]                seg_o,
    output logic                      dp_o,
    output logic [NUM_DIGITS-1:0]     an_o,
    output logic                      frame_done_o
);

    localparam int MAX_T = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
    localparam int TW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;
    localparam int IW    = $clog2(NUM_DIGITS);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_TICKS - 1);
    localparam logic [TW-1:0] DIGIT_LAST = TW'(DIGIT_TICKS - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic {S_BLANK, S_SHOW} state_e;

    state_e                    state_q, state_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [TW-1:0]             tick_q, tick_d;
    logic                      boundary;

    logic                      shadow_full_q, shadow_full_d;
    logic [4*NUM_DIGITS-1:0]   shadow_digits_q, shadow_digits_d;
    logic [NUM_DIGITS-1:0]     shadow_dp_q, shadow_dp_d;
    logic [NUM_DIGITS-1:0]     shadow_en_q, shadow_en_d;

    logic [4*NUM_DIGITS-1:0]   active_digits_q, active_digits_d;
    logic [NUM_DIGITS-1:0]     active_dp_q, active_dp_d;
    logic [NUM_DIGITS-1:0]     active_en_q, active_en_d;

    logic [NUM_DIGITS-1:0]     an_q, an_d;
    logic [6:0]                seg_q, seg_d;
    logic                      dp_q, dp_d;
    logic                      frame_done_q, frame_done_d;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

`ifdef SEG7_LZB_EN
    // Walk down from the most significant digit; digits stay masked while every nibble above is zero.
    function automatic logic [NUM_DIGITS-1:0] lzb_mask(input logic [4*NUM_DIGITS-1:0] d);
        logic [NUM_DIGITS-1:0] m;
        logic                  zeros;
        m     = '1;
        zeros = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zeros = zeros & (d[4*k +: 4] == 4'h0);
            if (zeros) m[k] = 1'b0;
        end
        return m;
    endfunction
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tick_d   = tick_q + 1'b1;
        boundary = 1'b0;
        case (state_q)
            S_BLANK: begin
                if (tick_q == BLANK_LAST) begin
                    state_d = S_SHOW;
                    tick_d  = '0;
                end
            end
            S_SHOW: begin
                if (tick_q == DIGIT_LAST) begin
                    state_d  = S_BLANK;
                    tick_d   = '0;
                    boundary = (idx_q == IDX_LAST);
                    idx_d    = boundary ? '0 : idx_q + 1'b1;
                end
            end
        endcase
    end

    // Transfer and load are mutually exclusive: a load needs an empty shadow, a transfer a full one.
    always_comb begin
        shadow_full_d   = shadow_full_q;
        shadow_digits_d = shadow_digits_q;
        shadow_dp_d     = shadow_dp_q;
        shadow_en_d     = shadow_en_q;
        active_digits_d = active_digits_q;
        active_dp_d     = active_dp_q;
        active_en_d     = active_en_q;
        if (boundary && shadow_full_q) begin
            active_digits_d = shadow_digits_q;
            active_dp_d     = shadow_dp_q;
`ifdef SEG7_LZB_EN
            active_en_d     = shadow_en_q & lzb_mask(shadow_digits_q);
`else
            active_en_d     = shadow_en_q;
`endif
            shadow_full_d   = 1'b0;
        end else if (load_valid_i && !shadow_full_q) begin
            shadow_full_d   = 1'b1;
            shadow_digits_d = digits_i;
            shadow_dp_d     = dp_i;
            shadow_en_d     = digit_en_i;
        end
    end

    // Outputs are decoded from the next state so they change on the transition edge itself.
    // The active buffer only changes when the next state is blank, so its current value is safe here.
    always_comb begin
        an_d         = '1;
        seg_d        = 7'h7F;
        dp_d         = 1'b1;
        frame_done_d = (state_d == S_SHOW) && (idx_d == IDX_LAST) && (tick_d == DIGIT_LAST);
        if (state_d == S_SHOW) begin
            seg_d = hex7(active_digits_q[{idx_d, 2'b00} +: 4]);
            dp_d  = ~active_dp_q[idx_d];
            if (active_en_q[idx_d]) an_d[idx_d] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_BLANK;
            idx_q           <= '0;
            tick_q          <= '0;
            shadow_full_q   <= 1'b0;
            active_digits_q <= '0;
            active_dp_q     <= '0;
            active_en_q     <= '0;
            an_q            <= '1;
            seg_q           <= 7'h7F;
            dp_q            <= 1'b1;
            frame_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            tick_q          <= tick_d;
            shadow_full_q   <= shadow_full_d;
            active_digits_q <= active_digits_d;
            active_dp_q     <= active_dp_d;
            active_en_q     <= active_en_d;
            an_q            <= an_d;
            seg_q           <= seg_d;
            dp_q            <= dp_d;
            frame_done_q    <= frame_done_d;
        end
    end

    // Shadow contents are qualified by shadow_full_q and need no reset.
    always_ff @(posedge clk_i) begin
        shadow_digits_q <= shadow_digits_d;
        shadow_dp_q     <= shadow_dp_d;
        shadow_en_q     <= shadow_en_d;
    end

    assign load_ready_o = ~shadow_full_q;
    assign an_o         = an_q;
    assign seg_o        = seg_q;
    assign dp_o         = dp_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_scheduler.sv
// Randomized bench for seg7_scan_scheduler with a slot-arithmetic reference model (8 digits, 4+1 ticks).
module tb_seg7_scan_scheduler;

    localparam int N     = 8;
    localparam int DT    = 4;
    localparam int BT    = 1;
    localparam int SLOT  = DT + BT;
    localparam int FRAME = N * SLOT;

    localparam logic [6:0] HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [31:0]   digits = '0;
    logic [7:0]    dp_in = '0;
    logic [7:0]    en_in = '0;
    logic [6:0]    seg;
    logic          dp_out;
    logic [7:0]    an;
    logic          frame_done;

    int checks = 0;
    int errors = 0;

    seg7_scan_scheduler #(.NUM_DIGITS(N), .DIGIT_TICKS(DT), .BLANK_TICKS(BT)) dut (
        .clk_i(clk), .reset_n(reset_n), .load_valid_i(load_valid), .load_ready_o(load_ready),
        .digits_i(digits), .dp_i(dp_in), .digit_en_i(en_in),
        .seg_o(seg), .dp_o(dp_out), .an_o(an), .frame_done_o(frame_done));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, t exceeded time budget");
        $fatal(1, "watchdog");
    end

    // Reference model: t is the index of the current cycle since reset release.
    int          t;
    logic        sfull;
    logic [31:0] sdig, adig;
    logic [7:0]  sdp, sen, adp, aen;

    function automatic logic [7:0] lzb_ref(input logic [31:0] d);
        int h = 0;
        logic [7:0] m = 8'hFF;
        for (int k = 0; k < N; k++) if (d[4*k +: 4] != 4'h0) h = k;
`ifdef SEG7_LZB_EN
        for (int k = 1; k < N; k++) if (k > h) m[k] = 1'b0;
`endif
        return m;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t <= 0; sfull <= 1'b0; adig <= '0; adp <= '0; aen <= '0;
        end else begin
            if ((t % FRAME) == FRAME - 1 && sfull) begin
                adig <= sdig; adp <= sdp; aen <= sen & lzb_ref(sdig); sfull <= 1'b0;
            end else if (load_valid && !sfull) begin
                sdig <= digits; sdp <= dp_in; sen <= en_in; sfull <= 1'b1;
            end
            t <= t + 1;
        end
    end

    // {an, seg, dp, frame_done, ready}
    function automatic logic [17:0] model_out();
        int p = t % FRAME;
        int s = p / SLOT;
        int w = p % SLOT;
        logic [7:0] e_an = 8'hFF;
        logic [6:0] e_seg = 7'h7F;
        logic       e_dp = 1'b1;
        if (w >= BT) begin
            e_seg = HEX[adig[4*s +: 4]];
            e_dp  = ~adp[s];
            if (aen[s]) e_an = ~(8'h01 << s);
        end
        return {e_an, e_seg, e_dp, (p == FRAME - 1), ~sfull};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, t);
        end
    endtask

    always @(negedge clk) begin
        chk("cycle_outputs", {14'd0, an, seg, dp_out, frame_done, load_ready}, {14'd0, model_out()});
    end

    task automatic goto(input int target);
        do @(negedge clk); while (t < target);
    endtask

    task automatic load_once(input logic [31:0] d, input logic [7:0] p, input logic [7:0] e);
        digits = d; dp_in = p; en_in = e; load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    initial begin
        int cnt;
        int ta;
        int nb;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        chk("reset_ready", {31'd0, load_ready}, 32'd1);
        chk("reset_an", {24'd0, an}, 32'hFF);

        // Idle frames: dark display and two frame pulses.
        cnt = 0;
        repeat (80) begin
            @(negedge clk);
            if (frame_done) cnt++;
            if (an !== 8'hFF) chk("idle_dark", {24'd0, an}, 32'hFF);
        end
        chk("idle_pulse_count", cnt, 2);

        // Single frame load, visible after next boundary.
        load_once(32'h8765_4321, 8'h01, 8'hFF);
        chk("ready_low_after_load", {31'd0, load_ready}, 32'd0);
        goto(121);
        chk("slot0_an", {24'd0, an}, 32'hFE);
        chk("slot0_seg", {25'd0, seg}, {25'd0, 7'b1111001});
        chk("slot0_dp", {31'd0, dp_out}, 32'd0);
        goto(125);
        chk("blank_an", {24'd0, an}, 32'hFF);
        goto(156);
        chk("slot7_seg", {25'd0, seg}, 32'd0);
        chk("slot7_an", {24'd0, an}, 32'h7F);

        // Frame A then frame B held valid while shadow is full.
        digits = $urandom; dp_in = 8'($urandom); en_in = 8'($urandom); load_valid = 1'b1;
        @(negedge clk);
        chk("ab_ready_low", {31'd0, load_ready}, 32'd0);
        digits = $urandom; dp_in = 8'($urandom); en_in = 8'hFF;
        for (int n = 0; n < 100 && !load_ready; n++) @(negedge clk);
        chk("ab_ready_rise_phase", t % FRAME, 0);
        @(negedge clk);
        load_valid = 1'b0;
        chk("ab_b_accepted", {31'd0, load_ready}, 32'd0);
        goto(240);

        // Sparse enables keep the frame period.
        load_once(32'h1234_5678, 8'h00, 8'h05);
        goto(281);
        chk("en05_slot0", {24'd0, an}, 32'hFE);
        goto(286);
        chk("en05_slot1", {24'd0, an}, 32'hFF);
        goto(291);
        chk("en05_slot2", {24'd0, an}, 32'hFB);
        goto(319);
        chk("en05_frame_done", {31'd0, frame_done}, 32'd1);

        // Random traffic.
        repeat (400) begin
            @(negedge clk);
            load_valid = ($urandom_range(0, 3) == 0);
            digits = $urandom; dp_in = 8'($urandom); en_in = 8'($urandom);
        end
        load_valid = 1'b0;

        // Leading-zero frame.
        for (int n = 0; n < 200 && !load_ready; n++) @(negedge clk);
        chk("lzb_ready_wait", {31'd0, load_ready}, 32'd1);
        ta = t;
        load_once(32'h0000_0A05, 8'h00, 8'hFF);
        nb = (ta / FRAME + 1) * FRAME;
        goto(nb + SLOT + 1);
        chk("lzb_slot1_seg", {25'd0, seg}, {25'd0, 7'b1000000});
        chk("lzb_slot1_an", {24'd0, an}, 32'hFD);
        goto(nb + 3 * SLOT + 1);
`ifdef SEG7_LZB_EN
        chk("lzb_slot3_an", {24'd0, an}, 32'hFF);
`else
        chk("lzb_slot3_an", {24'd0, an}, 32'hF7);
`endif

        // Asynchronous reset in the middle of slot 3.
        goto((t / FRAME + 1) * FRAME + 17);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_an", {24'd0, an}, 32'hFF);
        chk("async_rst_seg", {25'd0, seg}, 32'h7F);
        chk("async_rst_dp", {31'd0, dp_out}, 32'd1);
        chk("async_rst_fd", {31'd0, frame_done}, 32'd0);
        chk("async_rst_ready", {31'd0, load_ready}, 32'd1);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        goto(17);
        chk("post_rst_dark", {24'd0, an}, 32'hFF);
        goto(45);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
